// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// single-word lines. It sits in front of a synchronous-read RAM, serves a
// CPU request/done handshake and keeps saturating read hit/miss counters.
module dm_cache_ctrl #(
  parameter int AWIDTH    = 3,
  parameter int DWIDTH    = 32,
  parameter int IDX_WIDTH = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AWIDTH-1:0]    cpu_addr,
  input  logic [DWIDTH-1:0]    cpu_wdata,
  output logic                 cpu_ready,
  output logic                 cpu_done,
  output logic [DWIDTH-1:0]    cpu_rdata,
  output logic [AWIDTH-1:0]    mem_addr,
  output logic [DWIDTH-1:0]    mem_din,
  output logic                 mem_we,
  input  logic [DWIDTH-1:0]    mem_dout,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int LINES = 1 << IDX_WIDTH;
  localparam int TW    = AWIDTH - IDX_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_RD   = 3'd1,
    MEM_WAIT = 3'd2,
    MEM_WR   = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Latched request; drives the RAM address/data directly.
  logic [AWIDTH-1:0]    req_addr_reg;
  logic [DWIDTH-1:0]    req_wdata_reg;
  logic                 req_we_reg;

  // Line storage: only the valid bits are reset.
  logic [LINES-1:0]     valid_reg;
  logic [TW-1:0]        tag_mem  [LINES];
  logic [DWIDTH-1:0]    data_mem [LINES];

  logic [DWIDTH-1:0]    rdata_reg;
  logic [CNT_WIDTH-1:0] hit_reg;
  logic [CNT_WIDTH-1:0] miss_reg;

  logic [IDX_WIDTH-1:0] cpu_idx;
  logic [TW-1:0]        cpu_tag;
  logic [IDX_WIDTH-1:0] req_idx;
  logic [TW-1:0]        req_tag;
  logic                 cpu_hit;
  logic                 req_hit;
  logic                 accept;
  logic                 line_wr_en;
  logic [DWIDTH-1:0]    line_wr_data;

  assign cpu_idx = cpu_addr[IDX_WIDTH-1:0];
  assign cpu_tag = cpu_addr[AWIDTH-1:IDX_WIDTH];
  assign req_idx = req_addr_reg[IDX_WIDTH-1:0];
  assign req_tag = req_addr_reg[AWIDTH-1:IDX_WIDTH];

  assign cpu_hit = valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign req_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept  = (state_reg == IDLE) && cpu_req;

  // A line is written on miss refill, or on a write that hits (no allocate).
  assign line_wr_en   = (state_reg == MEM_WAIT) || ((state_reg == MEM_WR) && req_hit);
  assign line_wr_data = (state_reg == MEM_WAIT) ? mem_dout : req_wdata_reg;

  // Outputs decoded straight from the state register and request latch.
  assign cpu_ready  = (state_reg == IDLE);
  assign cpu_done   = (state_reg == RESP);
  assign mem_we     = (state_reg == MEM_WR);
  assign mem_addr   = req_addr_reg;
  assign mem_din    = req_wdata_reg;
  assign cpu_rdata  = rdata_reg;
  assign hit_count  = hit_reg;
  assign miss_count = miss_reg;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we)       state_next = MEM_WR;
          else if (cpu_hit) state_next = RESP;
          else              state_next = MEM_RD;
        end
      end
      MEM_RD:   state_next = MEM_WAIT;
      MEM_WAIT: state_next = RESP;
      MEM_WR:   state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State, request latch, valid bits, read data and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_we_reg    <= 1'b0;
      valid_reg     <= '0;
      rdata_reg     <= '0;
      hit_reg       <= '0;
      miss_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        req_addr_reg  <= cpu_addr;
        req_wdata_reg <= cpu_wdata;
        req_we_reg    <= cpu_we;
        if (!cpu_we) begin
          if (cpu_hit) begin
            rdata_reg <= data_mem[cpu_idx];
            if (hit_reg != {CNT_WIDTH{1'b1}}) hit_reg <= hit_reg + CNT_WIDTH'(1);
          end else begin
            if (miss_reg != {CNT_WIDTH{1'b1}}) miss_reg <= miss_reg + CNT_WIDTH'(1);
          end
        end
      end
      if (state_reg == MEM_WAIT) begin
        rdata_reg          <= mem_dout;
        valid_reg[req_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; an abandoned refill during reset leaves them alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LINES; i++) begin
      if (!reset && line_wr_en && (req_idx == IDX_WIDTH'(i))) begin
        tag_mem[i]  <= req_tag;
        data_mem[i] <= line_wr_data;
      end
    end
  end

endmodule
